// File: rtl/peripheral_adder_sequencer.sv
// Nibble-serial add/subtract controller driving a shared 4-bit adder.
// One nibble per clock, LSB first, with registered inter-nibble carry.
module peripheral_adder_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy,
  output logic [3:0]       add_x,
  output logic [3:0]       add_y,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [IW-1:0]    idx;
  logic             run;
  logic             done;
  logic             last;

  assign run  = (state == RUN);
  assign done = (state == DONE);
  assign last = (idx == IW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Subtract is A + ~B + 1; the +1 rides in on the carry.
            a_r     <= req_a;
            b_r     <= req_sub ? ~req_b : req_b;
            carry_r <= req_sub ? 1'b1 : req_cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_r[4*idx +: 4] <= add_sum;
          carry_r           <= add_cout;
          if (last) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = run | done;
  assign rsp_valid = done;

  assign add_x   = run ? a_r[4*idx +: 4] : 4'h0;
  assign add_y   = run ? b_r[4*idx +: 4] : 4'h0;
  assign add_cin = run & carry_r;

  assign rsp_sum  = done ? sum_r : '0;
  assign rsp_cout = done & carry_r;
  assign rsp_ovf  = done
                  & (a_r[WIDTH-1] == b_r[WIDTH-1])
                  & (sum_r[WIDTH-1] != a_r[WIDTH-1]);

endmodule

// File: tb/tb_peripheral_adder_sequencer.sv
// Directed bench for peripheral_adder_sequencer with a behavioral
// 4-bit adder standing in for the shared peripheral.
module tb_peripheral_adder_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_cin;
  logic        req_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_sum;
  logic        rsp_cout;
  logic        rsp_ovf;
  logic        busy;
  logic [3:0]  add_x;
  logic [3:0]  add_y;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {4'h0, add_cin};

  peripheral_adder_sequencer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rsp_sum"}, rsp_sum, 16'h0);
    chk({tag, "_rsp_cout"}, rsp_cout, 1'b0);
    chk({tag, "_rsp_ovf"}, rsp_ovf, 1'b0);
    chk({tag, "_add_x"}, add_x, 4'h0);
    chk({tag, "_add_y"}, add_y, 4'h0);
    chk({tag, "_add_cin"}, add_cin, 1'b0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready_wait"}, req_ready, 1'b1);
  endtask

  task automatic accept(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic cin,
                        input logic sub);
    wait_ready(tag);
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    req_sub   = sub;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_a     = 16'h0;
    req_b     = 16'h0;
    req_cin   = 1'b0;
    req_sub   = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic cin,
                       input logic sub, input logic [15:0] es,
                       input logic ec, input logic eo, input int hold);
    logic [15:0] beff;
    beff = sub ? ~b : b;
    accept(tag, a, b, cin, sub);
    chk({tag, "_cin0"}, add_cin, sub ? 1'b1 : cin);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_x%0d", tag, k), add_x, a[4*k +: 4]);
      chk($sformatf("%s_y%0d", tag, k), add_y, beff[4*k +: 4]);
      chk($sformatf("%s_nv%0d", tag, k), rsp_valid, 1'b0);
      chk($sformatf("%s_busy%0d", tag, k), busy, 1'b1);
      tick();
    end
    rsp_ready = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      chk($sformatf("%s_valid_h%0d", tag, h), rsp_valid, 1'b1);
      chk($sformatf("%s_sum_h%0d", tag, h), rsp_sum, es);
      chk($sformatf("%s_cout_h%0d", tag, h), rsp_cout, ec);
      chk($sformatf("%s_ovf_h%0d", tag, h), rsp_ovf, eo);
      chk($sformatf("%s_rdy_h%0d", tag, h), req_ready, 1'b0);
      chk($sformatf("%s_addx_h%0d", tag, h), add_x, 4'h0);
      if (h < hold) begin
        // Stray request while the response is stalled must be ignored.
        req_a     = 16'hAAAA;
        req_b     = 16'h5555;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_post_valid"}, rsp_valid, 1'b0);
    chk({tag, "_post_ready"}, req_ready, 1'b1);
    chk({tag, "_post_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = 16'h0;
    req_b     = 16'h0;
    req_cin   = 1'b0;
    req_sub   = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    idle_chk("reset");
    rst = 1'b0;
    tick();
    idle_chk("reset_idle");

    do_op("add",    16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 0);
    do_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op("ovf_p",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_op("ovf_n",  16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
    do_op("cin",    16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
    do_op("sub_n",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    do_op("sub_p",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 0);
    do_op("bp",     16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 3);

    accept("rst_run", 16'h1234, 16'h0FCD, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_chk("rst_run");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rst_run_quiet%0d", i), rsp_valid, 1'b0);
      tick();
    end
    do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
